band_scale_mc: RTL and testbench

//  Multi-channel successor to the single-band pot gain stage. Squares each channel's pot,

---
 rtl/band_scale_mc.sv | 168 ++++++++++++++++
 tb/tb_band_scale_mc.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/band_scale_mc.sv
// Multi-channel pot-controlled gain stage: squares each pot, ramps the per-channel gain toward it,
// and scales signed audio through one time-shared multiplier with saturated outputs.
module band_scale_mc #(
   parameter int unsigned CH        = 4,
   parameter int unsigned POT_W     = 12,
   parameter int unsigned AUD_W     = 16,
   parameter int unsigned RAMP_STEP = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [CH*POT_W-1:0]   pot,
   input  logic [CH*AUD_W-1:0]   audio,
   output logic [CH*AUD_W-1:0]   scaled,
   output logic                  out_valid,
   output logic                  busy,
   output logic                  overrun
);

   localparam int unsigned PW = POT_W + AUD_W + 1;
   localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;
   localparam logic [POT_W-1:0] StepW = POT_W'(RAMP_STEP);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e                   state_q;
   logic [CW-1:0]            idx_q;
   logic                     drain_q;
   logic [CH*POT_W-1:0]      pot_q;
   logic [CH*AUD_W-1:0]      aud_q;
   logic [POT_W-1:0]         gain_q [CH];

   logic                     s1_vld_q;
   logic [CW-1:0]            s1_ch_q;
   logic [POT_W-1:0]         s1_g_q;
   logic signed [AUD_W-1:0]  s1_aud_q;
   logic                     s2_vld_q;
   logic [CW-1:0]            s2_ch_q;
   logic signed [PW-1:0]     prod_q;
   logic [CH*AUD_W-1:0]      shadow_q;
   logic [CH*AUD_W-1:0]      shadow_d;

   // S1: target gain and ramp limiting for the channel being issued
   logic [POT_W-1:0]         cur_pot;
   logic [POT_W-1:0]         cur_gain;
   logic [2*POT_W-1:0]       sq;
   logic [POT_W-1:0]         tgt;
   logic [POT_W-1:0]         diff;
   logic [POT_W-1:0]         g;

   always_comb begin
      cur_pot  = pot_q[idx_q*POT_W +: POT_W];
      cur_gain = gain_q[idx_q];
      sq       = cur_pot * cur_pot;
      tgt      = POT_W'(sq >> POT_W);
      diff     = '0;
      g        = tgt;
      if (RAMP_STEP != 0) begin
         if (tgt > cur_gain) begin
            diff = tgt - cur_gain;
            g    = (32'(diff) > RAMP_STEP) ? cur_gain + StepW : tgt;
         end else begin
            diff = cur_gain - tgt;
            g    = (32'(diff) > RAMP_STEP) ? cur_gain - StepW : tgt;
         end
      end
   end

   // S3: rescale to unity and saturate into the shadow buffer
   logic signed [PW-1:0]     res;
   logic [PW-AUD_W:0]        res_hi;
   logic [AUD_W-1:0]         res_sat;

   always_comb begin
      res    = prod_q >>> (POT_W - 2);
      res_hi = res[PW-1:AUD_W-1];
      if ((&res_hi) || !(|res_hi)) begin
         res_sat = res[AUD_W-1:0];
      end else if (res[PW-1]) begin
         res_sat = {1'b1, {(AUD_W-1){1'b0}}};
      end else begin
         res_sat = {1'b0, {(AUD_W-1){1'b1}}};
      end
      shadow_d = shadow_q;
      if (s2_vld_q) begin
         shadow_d[s2_ch_q*AUD_W +: AUD_W] = res_sat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         s1_ch_q  <= '0;
         s1_g_q   <= '0;
         s1_aud_q <= '0;
         s2_vld_q <= 1'b0;
         s2_ch_q  <= '0;
         prod_q   <= '0;
         shadow_q <= '0;
         for (int i = 0; i < int'(CH); i++) begin
            gain_q[i] <= '0;
         end
      end else begin
         s1_vld_q <= (state_q == StRun);
         if (state_q == StRun) begin
            gain_q[idx_q] <= g;
            s1_ch_q       <= idx_q;
            s1_g_q        <= g;
            s1_aud_q      <= aud_q[idx_q*AUD_W +: AUD_W];
         end
         s2_vld_q <= s1_vld_q;
         s2_ch_q  <= s1_ch_q;
         prod_q   <= $signed({1'b0, s1_g_q}) * s1_aud_q;
         shadow_q <= shadow_d;
      end
   end

   // The final channel lands in shadow_d on the last drain cycle, so scaled takes shadow_d.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         drain_q   <= 1'b0;
         pot_q     <= '0;
         aud_q     <= '0;
         scaled    <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         overrun   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  pot_q   <= pot;
                  aud_q   <= audio;
                  idx_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               overrun <= in_valid;
               if (idx_q == CW'(CH - 1)) begin
                  drain_q <= 1'b0;
                  state_q <= StDrain;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            StDrain: begin
               overrun <= in_valid;
               if (drain_q) begin
                  scaled    <= shadow_d;
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
                  state_q   <= StIdle;
               end else begin
                  drain_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_band_scale_mc.sv
// Bench for band_scale_mc: a jump-gain instance and a ramping instance share stimulus and are
// compared against constant vectors and an arithmetic reference model.
module tb_band_scale_mc;

   localparam int CH = 4;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [47:0]   pot;
   logic [63:0]   audio;
   logic [63:0]   scaled0, scaled1;
   logic          out_valid0, out_valid1, busy0, busy1, overrun0, overrun1;

   band_scale_mc #(.CH(4), .POT_W(12), .AUD_W(16), .RAMP_STEP(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .pot(pot), .audio(audio),
      .scaled(scaled0), .out_valid(out_valid0), .busy(busy0), .overrun(overrun0)
   );

   band_scale_mc #(.CH(4), .POT_W(12), .AUD_W(16), .RAMP_STEP(256)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .pot(pot), .audio(audio),
      .scaled(scaled1), .out_valid(out_valid1), .busy(busy1), .overrun(overrun1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   int          g0 [CH];
   int          g1 [CH];
   logic [63:0] exp0, exp1;

   typedef struct {
      logic [47:0] p;
      logic [63:0] a;
      logic [63:0] e;
   } vec_t;
   vec_t tbl [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic logic [47:0] pk_p(input int a, input int b, input int c, input int d);
      return {12'(d), 12'(c), 12'(b), 12'(a)};
   endfunction

   function automatic logic [63:0] pk_a(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   function automatic int target(input int p);
      return (p * p) / 4096;
   endfunction

   function automatic int ramp(input int cur, input int tgt, input int step);
      if (step == 0) return tgt;
      if (tgt > cur) return (tgt - cur > step) ? cur + step : tgt;
      return (cur - tgt > step) ? cur - step : tgt;
   endfunction

   function automatic logic [15:0] scale(input int gain, input int a);
      longint pr;
      pr = longint'(gain) * longint'(a);
      pr = pr >>> 10;
      if (pr > 32767) pr = 32767;
      if (pr < -32768) pr = -32768;
      return 16'(pr);
   endfunction

   task automatic model_accept(input logic [47:0] p, input logic [63:0] a);
      for (int k = 0; k < CH; k++) begin
         int t;
         int av;
         t     = target(int'(p[k*12 +: 12]));
         av    = int'($signed(a[k*16 +: 16]));
         g0[k] = ramp(g0[k], t, 0);
         g1[k] = ramp(g1[k], t, 256);
         exp0[k*16 +: 16] = scale(g0[k], av);
         exp1[k*16 +: 16] = scale(g1[k], av);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < CH; k++) begin
         g0[k] = 0;
         g1[k] = 0;
      end
      exp0 = '0;
      exp1 = '0;
   endtask

   task automatic run_sample(input logic [47:0] p, input logic [63:0] a);
      int lat;
      model_accept(p, a);
      pot      = p;
      audio    = a;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("busy_after_accept", 64'(busy0), 64'd1);
      lat = 1;
      while (!out_valid0 && lat < 20) begin
         tick();
         lat++;
      end
      chk("latency", 64'(lat), 64'd7);
      chk("out_valid_ramp_inst", 64'(out_valid1), 64'd1);
      chk("busy_clear_at_out", 64'(busy0), 64'd0);
      chk("scaled_jump_model", scaled0, exp0);
      chk("scaled_ramp_model", scaled1, exp1);
      tick();
      chk("out_valid_pulse", 64'(out_valid0), 64'd0);
   endtask

   initial begin
      int lat;
      int got;
      int ramp_up [5];
      logic [47:0] p;
      logic [63:0] a;

      tbl[0] = '{pk_p(2048, 2048, 2048, 2048), pk_a(1000, -1000, 0, 32767),
                 pk_a(1000, -1000, 0, 32767)};
      tbl[1] = '{pk_p(4095, 4095, 4095, 4095), pk_a(16000, -16000, 100, -100),
                 pk_a(32767, -32768, 399, -400)};
      tbl[2] = '{pk_p(0, 1024, 2048, 4095), pk_a(2000, 2000, 2000, 2000),
                 pk_a(0, 500, 2000, 7996)};
      tbl[3] = '{pk_p(2048, 2048, 2048, 2048), pk_a(-32768, 32767, 1, -1),
                 pk_a(-32768, 32767, 1, -1)};
      ramp_up = '{256, 512, 768, 1024, 1024};

      in_valid = 1'b0;
      pot      = '0;
      audio    = '0;
      rst      = 1'b1;
      model_reset();
      repeat (3) tick();
      rst = 1'b0;

      chk("rst_scaled", scaled0, 64'd0);
      chk("rst_out_valid", 64'(out_valid0), 64'd0);
      chk("rst_busy", 64'(busy0), 64'd0);
      chk("rst_overrun", 64'(overrun0), 64'd0);

      // Fade-in from zero gain on the ramping instance, then fade-out
      for (int i = 0; i < 5; i++) begin
         run_sample(pk_p(2048, 2048, 2048, 2048), pk_a(1024, 1024, 1024, 1024));
         chk("ramp_up_ch0", 64'(scaled1[15:0]), 64'(ramp_up[i]));
         chk("ramp_up_ch3", 64'(scaled1[63:48]), 64'(ramp_up[i]));
         chk("jump_unity", 64'(scaled0[15:0]), 64'd1024);
      end
      run_sample(pk_p(0, 0, 0, 0), pk_a(1024, 1024, 1024, 1024));
      chk("ramp_down_1", 64'(scaled1[15:0]), 64'd768);
      run_sample(pk_p(0, 0, 0, 0), pk_a(1024, 1024, 1024, 1024));
      chk("ramp_down_2", 64'(scaled1[15:0]), 64'd512);

      for (int i = 0; i < 4; i++) begin
         run_sample(tbl[i].p, tbl[i].a);
         chk("table_vec", scaled0, tbl[i].e);
      end

      // Overrun during RUN, then back-to-back acceptance in the out_valid cycle
      model_accept(pk_p(2048, 1024, 4095, 0), pk_a(300, -300, 5000, 77));
      pot      = pk_p(2048, 1024, 4095, 0);
      audio    = pk_a(300, -300, 5000, 77);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      pot      = pk_p(100, 100, 100, 100);
      audio    = pk_a(9, 9, 9, 9);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("overrun_pulse", 64'(overrun0), 64'd1);
      tick();
      chk("overrun_one_cycle", 64'(overrun0), 64'd0);
      chk("no_early_out_5", 64'(out_valid0), 64'd0);
      tick();
      chk("no_early_out_6", 64'(out_valid0), 64'd0);
      tick();
      chk("out_at_t7", 64'(out_valid0), 64'd1);
      chk("overrun_kept_jump", scaled0, exp0);
      chk("overrun_kept_ramp", scaled1, exp1);
      model_accept(pk_p(4095, 2048, 1024, 512), pk_a(-20000, 4000, -4000, 12345));
      pot      = pk_p(4095, 2048, 1024, 512);
      audio    = pk_a(-20000, 4000, -4000, 12345);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("accept_at_t7_busy", 64'(busy0), 64'd1);
      chk("accept_at_t7_no_overrun", 64'(overrun0), 64'd0);
      lat = 8;
      while (!out_valid0 && lat < 30) begin
         tick();
         lat++;
      end
      chk("second_out_t14", 64'(lat), 64'd14);
      chk("second_jump", scaled0, exp0);
      chk("second_ramp", scaled1, exp1);
      tick();

      // Reset mid-RUN discards the set and clears gains
      pot      = pk_p(2048, 2048, 2048, 2048);
      audio    = pk_a(1024, 1024, 1024, 1024);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      chk("midrun_rst_busy", 64'(busy0), 64'd0);
      chk("midrun_rst_scaled0", scaled0, 64'd0);
      chk("midrun_rst_scaled1", scaled1, 64'd0);
      got = 0;
      repeat (10) begin
         tick();
         if (out_valid0 || out_valid1) got = 1;
      end
      chk("no_out_after_rst", 64'(got), 64'd0);
      run_sample(pk_p(2048, 2048, 2048, 2048), pk_a(1024, 1024, 1024, 1024));
      chk("ramp_restart", 64'(scaled1[15:0]), 64'd256);

      // Randomized sets against the reference model
      for (int i = 0; i < 25; i++) begin
         for (int k = 0; k < CH; k++) begin
            p[k*12 +: 12] = 12'($urandom_range(0, 4095));
            a[k*16 +: 16] = 16'($urandom);
         end
         run_sample(p, a);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
